// File: rtl/fp_to_int_if.sv
// Handshake bundle for the float -> integer converter: operand in, result out.
interface fp_to_int_if #(
   parameter int NX = 8,
   parameter int NM = 23,
   parameter int NI = 32
) ();
   logic              in_valid;
   logic              in_ready;
   logic [NX+NM:0]    in_fp;
   logic              out_valid;
   logic              out_ready;
   logic [NI-1:0]     out_int;
   logic [2:0]        out_flags;   // {invalid, overflow, inexact}

   modport master (
      output in_valid, in_fp, out_ready,
      input  in_ready, out_valid, out_int, out_flags
   );

   modport slave (
      input  in_valid, in_fp, out_ready,
      output in_ready, out_valid, out_int, out_flags
   );
endinterface

// File: rtl/fp_to_int_seq.sv
// Sequential IEEE754 -> signed NI-bit integer converter.
// The significand is aligned one bit per cycle, then rounded and saturated.
// Optional feature macro: FP_TO_INT_RNE_EN (round to nearest even);
// without it the magnitude is truncated toward zero.
module fp_to_int_seq #(
   parameter int NX = 8,
   parameter int NM = 23,
   parameter int NI = 32
) (
   input logic        clk,
   input logic        rst_n,
   fp_to_int_if.slave io
);
   // Integer field above a guard/round/sticky tail; wide enough that the
   // largest non-saturating left shift (e = NI-2) never loses a bit.
   localparam int W    = NI + NM + 3;
   localparam int CW   = $clog2(NI + NM + 2);
   localparam int BIAS = (1 << (NX - 1)) - 1;
   localparam logic [NI-1:0] INT_MIN = {1'b1, {(NI-1){1'b0}}};
   localparam logic [NI-1:0] INT_MAX = ~INT_MIN;

   typedef enum logic [1:0] {IDLE, ALIGN, ROUND, DONE} state_t;
   state_t state, state_nx;

   logic          sign_q;
   logic          left_q;
   logic [W-1:0]  work;
   logic [CW-1:0] cnt;

   // Operand decode
   logic          sgn_i;
   logic [NX-1:0] exp_i;
   logic [NM-1:0] mant_i;
   int            e_i;
   int            n_i;
   assign sgn_i  = io.in_fp[NX+NM];
   assign exp_i  = io.in_fp[NX+NM-1:NM];
   assign mant_i = io.in_fp[NM-1:0];
   assign e_i    = int'(exp_i) - BIAS;
   assign n_i    = (e_i < NM) ? (NM - e_i) : (e_i - NM);

   assign io.in_ready = (state == IDLE);

   // Special operands and out-of-range exponents resolve without alignment
   logic          fast;
   logic [NI-1:0] fast_int;
   logic [2:0]    fast_flags;
   always_comb begin
      fast       = 1'b1;
      fast_int   = '0;
      fast_flags = '0;
      if (&exp_i) begin
         if (|mant_i) begin
            fast_flags = 3'b100;
         end else begin
            fast_int   = sgn_i ? INT_MIN : INT_MAX;
            fast_flags = 3'b010;
         end
      end else if (exp_i == '0) begin
         fast_flags = {2'b00, |mant_i};
      end else if (e_i < -1) begin
         fast_flags = 3'b001;
      end else if (e_i >= NI - 1) begin
         // -2^(NI-1) is the one value at this exponent that fits exactly
         if (sgn_i && (e_i == NI - 1) && (mant_i == '0)) begin
            fast_int = INT_MIN;
         end else begin
            fast_int   = sgn_i ? INT_MIN : INT_MAX;
            fast_flags = 3'b010;
         end
      end else begin
         fast = 1'b0;
      end
   end

   // Rounding, sign application and saturation of the aligned magnitude
   logic [NI+NM-1:0] mag, mag_r;
   logic             g, r, s, inc, ovf;
   logic [NI-1:0]    rnd_int;
   logic [2:0]       rnd_flags;
   always_comb begin
      mag = work[W-1:3];
      g   = work[2];
      r   = work[1];
      s   = work[0];
`ifdef FP_TO_INT_RNE_EN
      inc = g & (r | s | mag[0]);
`else
      inc = 1'b0;
`endif
      mag_r     = mag + {{(NI+NM-1){1'b0}}, inc};
      ovf       = !sign_q && (|mag_r[NI+NM-1:NI-1]);
      rnd_int   = ovf ? INT_MAX : (sign_q ? ('0 - mag_r[NI-1:0]) : mag_r[NI-1:0]);
      rnd_flags = {1'b0, ovf, g | r | s};
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:  if (io.in_valid) state_nx = fast ? DONE : ALIGN;
         ALIGN: if (cnt == '0) state_nx = ROUND;
         ROUND: state_nx = DONE;
         DONE:  if (io.out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Datapath: capture, 1-bit/cycle alignment, result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sign_q       <= 1'b0;
         left_q       <= 1'b0;
         work         <= '0;
         cnt          <= '0;
         io.out_valid <= 1'b0;
         io.out_int   <= '0;
         io.out_flags <= '0;
      end else begin
         case (state)
            IDLE: if (io.in_valid) begin
               sign_q <= sgn_i;
               left_q <= (e_i > NM);
               work   <= {{(NI-1){1'b0}}, 1'b1, mant_i, 3'b000};
               cnt    <= CW'(n_i);
               if (fast) begin
                  io.out_int   <= fast_int;
                  io.out_flags <= fast_flags;
                  io.out_valid <= 1'b1;
               end
            end
            ALIGN: if (cnt != '0) begin
               cnt <= cnt - CW'(1);
               // right shifts fold the dropped bit into sticky
               if (left_q) work <= {work[W-2:0], 1'b0};
               else        work <= {1'b0, work[W-1:2], work[1] | work[0]};
            end
            ROUND: begin
               io.out_int   <= rnd_int;
               io.out_flags <= rnd_flags;
               io.out_valid <= 1'b1;
            end
            DONE: if (io.out_ready) io.out_valid <= 1'b0;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_fp_to_int_seq.sv
// Directed bench for fp_to_int_seq (NX=8, NM=23, NI=32); expectations follow
// the rounding mode selected by FP_TO_INT_RNE_EN.
module tb_fp_to_int_seq;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

`ifdef FP_TO_INT_RNE_EN
   localparam bit RNE = 1'b1;
`else
   localparam bit RNE = 1'b0;
`endif

   fp_to_int_if #(.NX(8), .NM(23), .NI(32)) bus ();
   fp_to_int_seq #(.NX(8), .NM(23), .NI(32)) dut (.clk(clk), .rst_n(rst_n), .io(bus.slave));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Present an operand, count edges from the accept edge until out_valid.
   task automatic start(input string tag, input logic [31:0] fp, output int lat);
      @(negedge clk);
      chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
      bus.in_fp    = fp;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      lat = 1;
      while (!bus.out_valid && lat < 200) begin
         @(posedge clk);
         #1 lat++;
      end
      chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd1);
   endtask

   task automatic release_result(input string tag);
      @(negedge clk) bus.out_ready = 1'b1;
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
      chk({tag, "_released"}, {30'b0, bus.out_valid, bus.in_ready}, 32'b01);
   endtask

   task automatic convert(input string tag, input logic [31:0] fp, input logic [31:0] ei,
                          input logic [2:0] ef, input int el);
      int lat;
      start(tag, fp, lat);
      chk({tag, "_int"}, bus.out_int, ei);
      chk({tag, "_flags"}, 32'(bus.out_flags), 32'(ef));
      if (el > 0) chk({tag, "_latency"}, 32'(lat), 32'(el));
      release_result(tag);
   endtask

   initial begin
      int lat;
      logic [31:0] held_int;
      logic [2:0]  held_flags;
      bus.in_valid  = 1'b0;
      bus.in_fp     = '0;
      bus.out_ready = 1'b0;

      // reset state
      #12;
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_int", bus.out_int, 32'd0);
      chk("rst_out_flags", 32'(bus.out_flags), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      #1 chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

      // aligned path, rounding cases
      convert("pi",     32'h40490FDB, 32'd3, 3'b001, -1);
      convert("p2_5",   32'h40200000, 32'd2, 3'b001, 25);
      convert("p3_5",   32'h40600000, RNE ? 32'd4 : 32'd3, 3'b001, 25);
      convert("m3_5",   32'hC0600000, RNE ? 32'hFFFFFFFC : 32'hFFFFFFFD, 3'b001, 25);
      convert("one",    32'h3F800000, 32'd1, 3'b000, 26);
      convert("mone",   32'hBF800000, 32'hFFFFFFFF, 3'b000, 26);
      convert("p1_5",   32'h3FC00000, RNE ? 32'd2 : 32'd1, 3'b001, 26);
      convert("p0_5",   32'h3F000000, 32'd0, 3'b001, 27);
      convert("p0_75",  32'h3F400000, RNE ? 32'd1 : 32'd0, 3'b001, 27);
      convert("big",    32'h4EFFFFFF, 32'h7FFFFF80, 3'b000, 10);
      convert("p2e30",  32'h4E800000, 32'h40000000, 3'b000, 10);
      convert("m2e30",  32'hCE800000, 32'hC0000000, 3'b000, 10);

      // fast path
      convert("m2e31",  32'hCF000000, 32'h80000000, 3'b000, 1);
      convert("p2e31",  32'h4F000000, 32'h7FFFFFFF, 3'b010, 1);
      convert("nan",    32'h7FC00000, 32'd0, 3'b100, 1);
      convert("ninf",   32'hFF800000, 32'h80000000, 3'b010, 1);
      convert("pinf",   32'h7F800000, 32'h7FFFFFFF, 3'b010, 1);
      convert("denorm", 32'h00000001, 32'd0, 3'b001, 1);
      convert("zero",   32'h80000000, 32'd0, 3'b000, 1);
      convert("p0_25",  32'h3E800000, 32'd0, 3'b001, 1);

      // result held while consumer stalls
      start("stall", 32'h40600000, lat);
      held_int   = bus.out_int;
      held_flags = bus.out_flags;
      chk("stall_int0", held_int, RNE ? 32'd4 : 32'd3);
      repeat (5) begin
         @(posedge clk);
         #1;
         chk("stall_valid", 32'(bus.out_valid), 32'd1);
         chk("stall_int", bus.out_int, held_int);
         chk("stall_flags", 32'(bus.out_flags), 32'(held_flags));
         chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
      end
      release_result("stall");
      chk("stall_keep_int", bus.out_int, held_int);

      // asynchronous reset in the middle of alignment
      convert("pre_rst", 32'h4E800000, 32'h40000000, 3'b000, 10);
      @(negedge clk);
      bus.in_fp    = 32'h3F800000;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("arst_out_int", bus.out_int, 32'd0);
      chk("arst_out_flags", 32'(bus.out_flags), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      #1 chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      #1 chk("arst_no_result", 32'(bus.out_valid), 32'd0);
      convert("ten", 32'h41200000, 32'd10, 3'b000, 23);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
